// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with TX FIFO, programmable baud divider and 8N1 frames.
// Define UART_PARITY_EN for 8E1 frames with an even-parity bit.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_F000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [2:0]  memsize,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        hit,
  output logic        tx,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     div_q, div_d, cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d, busy_q, busy_d;
  logic [1:0]      sel;
  logic            wr_en, push, push_ok, pop, full, empty, bit_end, ov_clr;
  logic [7:0]      head;
  logic [31:0]     status;
  logic            unused_bits;
`ifdef UART_PARITY_EN
  logic            par_q, par_d;
`endif
  assign unused_bits = ^{memsize, addr[1:0], writedata[31:16]};
  assign hit     = addr[31:4] == BASE_ADDR[31:4];
  assign sel     = addr[3:2];
  assign wr_en   = memwrite & hit;
  assign push    = wr_en & (sel == 2'd0);
  assign full    = count_q == CW'(FIFO_DEPTH);
  assign empty   = count_q == '0;
  assign push_ok = push & ~full;
  assign ov_clr  = wr_en & (sel == 2'd1) & writedata[3];
  assign head    = mem_q[rd_ptr_q];
  assign bit_end = cnt_q >= div_q - 16'd1;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign status  = {16'b0, 8'(count_q), 3'b0, PAR_EN, overflow_q, busy_q, empty, full};
  assign readdata = !hit ? 32'b0 : (sel == 2'd1) ? status : (sel == 2'd2) ? {16'b0, div_q} : 32'b0;
  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = writedata[7:0];
    wr_ptr_d   = wr_ptr_q + AW'(push_ok);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(push_ok) - CW'(pop);
    overflow_d = (push & full) | (overflow_q & ~ov_clr);
    div_d      = (wr_en && sel == 2'd2) ? ((writedata[15:0] < 16'd2) ? 16'd2 : writedata[15:0]) : div_q;
  end
  // A shortened divisor makes bit_end true at once, so the current bit ends on the next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE) ? 16'd0 : (bit_end ? 16'd0 : cnt_q + 16'd1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        shift_d = head;
        state_d = START;
        tx_d    = 1'b0;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = 3'd0;
        tx_d    = shift_q[0];
      end
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
          state_d = PARITY;
          tx_d    = par_q;
`else
          state_d = STOP;
          tx_d    = 1'b1;
`endif
        end else begin
          bit_d = bit_q + 3'd1;
          tx_d  = shift_q[1];
        end
      end
`ifdef UART_PARITY_EN
      PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
`endif
      STOP: if (bit_end) begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
          tx_d    = 1'b0;
        end else begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = state_d != IDLE;
  end
`ifdef UART_PARITY_EN
  assign par_d = pop ? ^head : par_q;
  always_ff @(posedge clk) begin
    if (reset) par_q <= 1'b0;
    else par_q <= par_d;
  end
`endif
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      div_q      <= DIV_RESET;
      cnt_q      <= 16'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed self-checking bench for mmio_uart_tx.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h0000_F000;
`ifdef UART_PARITY_EN
  localparam logic [31:0] PB = 32'h10;
  localparam bit PAR = 1'b1;
`else
  localparam logic [31:0] PB = 32'h0;
  localparam bit PAR = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [2:0]  memsize = 3'b010;
  logic [31:0] addr = 32'b0;
  logic [31:0] writedata = 32'b0;
  logic [31:0] readdata;
  logic        hit, tx, busy;
  int tests = 0;
  int fails = 0;
  mmio_uart_tx dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memsize(memsize), .addr(addr),
    .writedata(writedata), .readdata(readdata), .hit(hit), .tx(tx), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memwrite = 1'b1;
    addr = a;
    writedata = d;
    @(negedge clk);
    memwrite = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    memwrite = 1'b0;
    addr = a;
    #1;
    d = readdata;
    h = hit;
  endtask
  task automatic test_reset;
    logic [31:0] d;
    logic h;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (tx !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL reset_out tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
    rd(BASE + 4, d, h);
    tests++; if (d !== (32'h2 | PB)) begin fails++; $display("FAIL reset_status got %h expected %h", d, 32'h2 | PB); end
    rd(BASE + 8, d, h);
    tests++; if (d !== 32'd868) begin fails++; $display("FAIL reset_div got %h expected %h", d, 32'd868); end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_frame;
    logic e [0:127];
    int n;
    int bad;
    logic [7:0] b;
    logic [31:0] d;
    logic h;
    b = 8'h55;
    n = 0;
    for (int j = 0; j < 4; j++) begin e[n] = 1'b0; n++; end
    for (int i = 0; i < 8; i++) for (int j = 0; j < 4; j++) begin e[n] = b[i]; n++; end
    for (int j = 0; j < 4; j++) begin e[n] = 1'b1; n++; end
    wr(BASE + 8, 32'd4);
    wr(BASE, 32'h55);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tests++;
      if (tx !== e[k] || busy !== 1'b1) begin
        fails++; bad++;
        if (bad < 5) $display("FAIL frame55 k=%0d tx=%b busy=%b expected tx=%b busy=1", k, tx, busy, e[k]);
      end
    end
    @(negedge clk);
    tests++; if (tx !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL frame55_end tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
    rd(BASE + 4, d, h);
    tests++; if (d !== (32'h2 | PB)) begin fails++; $display("FAIL frame55_status got %h expected %h", d, 32'h2 | PB); end
  endtask
  task automatic test_div_regs;
    logic [31:0] d;
    logic h;
    wr(BASE + 8, 32'd1);
    rd(BASE + 8, d, h);
    tests++; if (d !== 32'h2) begin fails++; $display("FAIL div_min1 got %h expected 00000002", d); end
    wr(BASE + 8, 32'd0);
    rd(BASE + 8, d, h);
    tests++; if (d !== 32'h2) begin fails++; $display("FAIL div_min0 got %h expected 00000002", d); end
    wr(BASE + 8, 32'hABCD_1234);
    rd(BASE + 8, d, h);
    tests++; if (d !== 32'h1234) begin fails++; $display("FAIL div_load got %h expected 00001234", d); end
    wr(BASE + 16 + 8, 32'd5);
    rd(BASE + 8, d, h);
    tests++; if (d !== 32'h1234) begin fails++; $display("FAIL div_outside got %h expected 00001234", d); end
    wr(BASE + 12, 32'hFFFF_FFFF);
    rd(BASE + 12, d, h);
    tests++; if (d !== 32'h0 || h !== 1'b1) begin fails++; $display("FAIL reg3 got %h hit=%b expected 0 hit=1", d, h); end
    rd(BASE + 16, d, h);
    tests++; if (d !== 32'h0 || h !== 1'b0) begin fails++; $display("FAIL miss got %h hit=%b expected 0 hit=0", d, h); end
    rd(BASE, d, h);
    tests++; if (d !== 32'h0 || h !== 1'b1) begin fails++; $display("FAIL txdata_read got %h hit=%b expected 0 hit=1", d, h); end
  endtask
  task automatic test_overflow;
    logic [31:0] d;
    logic h;
    wr(BASE + 8, 32'd1000);
    for (int i = 0; i < 10; i++) wr(BASE, i);
    rd(BASE + 4, d, h);
    tests++; if (d !== (32'h080D | PB)) begin fails++; $display("FAIL ovf_status got %h expected %h", d, 32'h080D | PB); end
    wr(BASE + 4, 32'h8);
    rd(BASE + 4, d, h);
    tests++; if (d !== (32'h0805 | PB)) begin fails++; $display("FAIL ovf_clear got %h expected %h", d, 32'h0805 | PB); end
  endtask
  task automatic test_reset_midframe;
    logic [31:0] d;
    logic h;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wr(BASE + 8, 32'd4);
    wr(BASE, 32'h08);
    wr(BASE, 32'h11);
    wr(BASE, 32'h22);
    repeat (13) @(negedge clk);
    tests++; if (tx !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL mid_bit3 tx=%b busy=%b expected tx=1 busy=1", tx, busy); end
    rd(BASE + 4, d, h);
    tests++; if (d !== (32'h0204 | PB)) begin fails++; $display("FAIL mid_status got %h expected %h", d, 32'h0204 | PB); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (tx !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL mid_reset tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
    rd(BASE + 4, d, h);
    tests++; if (d !== (32'h2 | PB)) begin fails++; $display("FAIL mid_reset_status got %h expected %h", d, 32'h2 | PB); end
    rd(BASE + 8, d, h);
    tests++; if (d !== 32'd868) begin fails++; $display("FAIL mid_reset_div got %h expected %h", d, 32'd868); end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_back_to_back;
    logic e [0:127];
    int n;
    int bad;
    logic [7:0] b;
    n = 0;
    for (int f = 0; f < 2; f++) begin
      b = (f == 0) ? 8'hA5 : 8'h3C;
      for (int j = 0; j < 3; j++) begin e[n] = 1'b0; n++; end
      for (int i = 0; i < 8; i++) for (int j = 0; j < 3; j++) begin e[n] = b[i]; n++; end
      if (PAR) for (int j = 0; j < 3; j++) begin e[n] = ^b; n++; end
      for (int j = 0; j < 3; j++) begin e[n] = 1'b1; n++; end
    end
    wr(BASE + 8, 32'd3);
    @(negedge clk);
    memwrite = 1'b1;
    addr = BASE;
    writedata = 32'hA5;
    @(negedge clk);
    writedata = 32'h3C;
    @(negedge clk);
    memwrite = 1'b0;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      tests++;
      if (tx !== e[k] || busy !== 1'b1) begin
        fails++; bad++;
        if (bad < 5) $display("FAIL b2b k=%0d tx=%b busy=%b expected tx=%b busy=1", k, tx, busy, e[k]);
      end
      @(negedge clk);
    end
    tests++; if (tx !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL b2b_end tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
  endtask
  task automatic test_parity;
    logic e [0:127];
    int n;
    int bad;
    logic [7:0] b;
    b = 8'h07;
    n = 0;
    for (int j = 0; j < 2; j++) begin e[n] = 1'b0; n++; end
    for (int i = 0; i < 8; i++) for (int j = 0; j < 2; j++) begin e[n] = b[i]; n++; end
    if (PAR) for (int j = 0; j < 2; j++) begin e[n] = 1'b1; n++; end
    for (int j = 0; j < 2; j++) begin e[n] = 1'b1; n++; end
    wr(BASE + 8, 32'd2);
    wr(BASE, 32'h07);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tests++;
      if (tx !== e[k] || busy !== 1'b1) begin
        fails++; bad++;
        if (bad < 5) $display("FAIL parity07 k=%0d tx=%b busy=%b expected tx=%b busy=1", k, tx, busy, e[k]);
      end
    end
    @(negedge clk);
    tests++; if (tx !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL parity07_end tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
  endtask
  initial begin
    test_reset;
    test_frame;
    test_div_regs;
    test_overflow;
    test_reset_midframe;
    test_back_to_back;
    test_parity;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
